// File: rtl/wisc_shift_pkg.sv
// Shared definitions for the sequential shift unit: mode encodings,
// FSM state type and the default datapath width.
package wisc_shift_pkg;

    localparam int DEF_DATA_W = 16;

    localparam logic [1:0] SHIFT_SRL = 2'b00;
    localparam logic [1:0] SHIFT_ROL = 2'b01;
    localparam logic [1:0] SHIFT_SLL = 2'b10;
    localparam logic [1:0] SHIFT_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic mode_is_legal(input logic [1:0] mode);
        return (mode != SHIFT_ILL);
    endfunction

endpackage

// File: rtl/shift_step_1b.sv
// One-bit shift step: produces the next working value and the bit that
// leaves the word (or wraps, for ROL). The illegal mode passes data through.
module shift_step_1b
    import wisc_shift_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_mode,
    output logic [DATA_W-1:0] o_data,
    output logic              o_carry
);

    always_comb begin
        o_data  = i_data;
        o_carry = 1'b0;
        case (i_mode)
            SHIFT_SRL: begin
                o_data  = {1'b0, i_data[DATA_W-1:1]};
                o_carry = i_data[0];
            end
            SHIFT_SLL: begin
                o_data  = {i_data[DATA_W-2:0], 1'b0};
                o_carry = i_data[DATA_W-1];
            end
            SHIFT_ROL: begin
                o_data  = {i_data[DATA_W-2:0], i_data[DATA_W-1]};
                o_carry = i_data[DATA_W-1];
            end
            default: begin
                o_data  = i_data;
                o_carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Handshaked multi-cycle shifter (SRL/ROL/SLL), one bit position per cycle,
// with carry-out, zero and illegal-mode flags on the result.
module shift_unit_seq
    import wisc_shift_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_imm,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_carry,
    output logic               out_zero,
    output logic               out_illegal
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_data;
    logic [SHAMT_W-1:0] r_count;
    logic [1:0]         r_mode;
    logic               r_carry;
    logic               r_illegal;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_load;
    logic               w_step;
    logic [DATA_W-1:0]  w_step_data;
    logic               w_step_carry;

    shift_step_1b #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_data  (r_data),
        .i_mode  (r_mode),
        .o_data  (w_step_data),
        .o_carry (w_step_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load = 1'b1;
                    // Zero shifts and illegal modes skip straight to the result.
                    if ((in_imm != '0) && mode_is_legal(in_mode)) begin
                        w_state_nxt = SHIFT;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            SHIFT: begin
                w_step = 1'b1;
                if (r_count <= CNT_ONE) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_count   <= '0;
            r_mode    <= SHIFT_SRL;
            r_carry   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_load) begin
            r_data    <= in_data;
            r_count   <= in_imm;
            r_mode    <= in_mode;
            r_carry   <= 1'b0;
            r_illegal <= !mode_is_legal(in_mode);
        end else if (w_step) begin
            r_data    <= w_step_data;
            r_carry   <= w_step_carry;
            r_count   <= r_count - CNT_ONE;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign out_data    = r_data;
    assign out_carry   = r_carry;
    assign out_illegal = r_illegal;
    // Gated by DONE so the flag reads 0 out of reset even though r_data is 0.
    assign out_zero    = (r_state == DONE) && (r_data == '0);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: directed cases plus random requests
// compared against an arithmetic model of the shift rules.
module tb_shift_unit_seq;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_carry;
    logic        out_zero;
    logic        out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    logic        busy   = 1'b0;
    logic        chk_en = 1'b0;
    logic [15:0] exp_data;
    logic        exp_carry;
    logic        exp_ill;

    logic [15:0] got_data;
    logic        got_carry, got_zero, got_ill;
    int          lat, waited;

    always #5 clk = ~clk;

    shift_unit_seq #(.DATA_W(16), .SHAMT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_imm      (in_imm),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_carry   (out_carry),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Result of shifting d by imm positions in mode m, as plain arithmetic.
    function automatic void model(input logic [15:0] d, input int imm, input logic [1:0] m,
                                  output logic [15:0] r, output logic c);
        int v;
        v = int'(d);
        r = d;
        c = 1'b0;
        if (m != 2'b11 && imm != 0) begin
            case (m)
                2'b00: begin r = 16'(v >> imm); c = 1'((v >> (imm - 1)) & 1); end
                2'b10: begin r = 16'(v << imm); c = 1'((v >> (W - imm)) & 1); end
                default: begin
                    r = 16'((v << imm) | (v >> (W - imm)));
                    c = r[0];
                end
            endcase
        end
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] d, input int k);
        int v;
        v = int'(d);
        return 16'((v >> k) | (v << (W - k)));
    endfunction

    // Continuous compare against the model while checking is enabled.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (busy) begin
                chk("in_ready_busy", 32'(in_ready), 32'd0);
                if (out_valid) begin
                    chk("out_data", 32'(out_data), 32'(exp_data));
                    chk("out_carry", 32'(out_carry), 32'(exp_carry));
                    chk("out_zero", 32'(out_zero), 32'(exp_data == 16'h0));
                    chk("out_illegal", 32'(out_illegal), 32'(exp_ill));
                end
            end else begin
                chk("in_ready_idle", 32'(in_ready), 32'd1);
                chk("out_valid_idle", 32'(out_valid), 32'd0);
            end
        end
    end

    // Issue one request, measure latency, optionally hold the result for
    // `hold` extra cycles, then consume it. Called at #1 after a posedge.
    task automatic send(input logic [15:0] d, input int imm, input logic [1:0] m,
                        input int hold, output int w);
        int l;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            $display("FAIL ready_timeout: in_ready stuck at 0");
            $fatal(1, "in_ready timeout");
        end
        model(d, imm, m, exp_data, exp_carry);
        exp_ill   = (m == 2'b11);
        in_valid  = 1'b1;
        in_data   = d;
        in_imm    = 4'(imm);
        in_mode   = m;
        out_ready = (hold == 0);
        @(posedge clk);
        busy = 1'b1;
        #1;
        in_valid = 1'b1;
        in_data  = (hold > 0) ? 16'hFFFF : 16'($urandom);
        in_imm   = 4'($urandom);
        in_mode  = 2'($urandom);
        l = 1;
        @(negedge clk);
        while (!out_valid && l < 40) begin
            @(negedge clk);
            l++;
        end
        chk("latency", 32'(l), (m == 2'b11 || imm == 0) ? 32'd1 : 32'(imm + 1));
        got_data  = out_data;
        got_carry = out_carry;
        got_zero  = out_zero;
        got_ill   = out_illegal;
        if (m == 2'b01 && imm != 0)
            chk("rol_vs_ror", 32'(out_data), 32'(ror(d, W - imm)));
        if (out_valid) begin
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
        end
        busy = 1'b0;
        #1;
        in_valid = 1'b0;
        lat = l;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_imm    = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        send(16'h8001, 4, 2'b00, 0, waited);
        chk("srl_data", 32'(got_data), 32'h0800);
        chk("srl_carry", 32'(got_carry), 32'd0);
        chk("srl_zero", 32'(got_zero), 32'd0);
        chk("srl_lat", 32'(lat), 32'd5);

        send(16'h8001, 1, 2'b01, 0, waited);
        chk("rol_data", 32'(got_data), 32'h0003);
        chk("rol_carry", 32'(got_carry), 32'd1);
        chk("rol_lat", 32'(lat), 32'd2);

        send(16'h0003, 15, 2'b10, 0, waited);
        chk("sll_data", 32'(got_data), 32'h8000);
        chk("sll_carry", 32'(got_carry), 32'd1);
        send(16'h0001, 15, 2'b10, 0, waited);
        chk("sll15_data", 32'(got_data), 32'h8000);
        send(got_data, 1, 2'b10, 0, waited);
        chk("sll_out_data", 32'(got_data), 32'h0000);
        chk("sll_out_carry", 32'(got_carry), 32'd1);
        chk("sll_out_zero", 32'(got_zero), 32'd1);

        send(16'h1234, 0, 2'b00, 0, waited);
        chk("imm0_data", 32'(got_data), 32'h1234);
        chk("imm0_carry", 32'(got_carry), 32'd0);
        chk("imm0_lat", 32'(lat), 32'd1);
        send(16'h1234, 5, 2'b11, 0, waited);
        chk("ill_data", 32'(got_data), 32'h1234);
        chk("ill_flag", 32'(got_ill), 32'd1);
        chk("ill_lat", 32'(lat), 32'd1);

        send(16'h00F0, 3, 2'b00, 3, waited);
        chk("bp_data", 32'(got_data), 32'h001E);
        chk("bp_ready_after", 32'(in_ready), 32'd1);
        send(16'hFFFF, 2, 2'b00, 0, waited);
        chk("bp_next_accept_wait", 32'(waited), 32'd0);
        chk("bp_next_data", 32'(got_data), 32'h3FFF);

        // Reset in the middle of a shift drops the operation silently.
        chk_en   = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_imm   = 4'd10;
        in_mode  = 2'b00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk_en = 1'b1;
        send(16'hFFFF, 1, 2'b00, 0, waited);
        chk("postrst_data", 32'(got_data), 32'h7FFF);
        chk("postrst_carry", 32'(got_carry), 32'd1);

        for (int i = 0; i < 150; i++) begin
            send(16'($urandom), int'($urandom_range(0, 15)), 2'($urandom),
                 int'($urandom_range(0, 2)), waited);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
